// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic accepts_bytes(loader_state_t s);
    return s inside {HDR0, HDR1, DATA};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/loader_word_pack.sv
// Little-endian byte-to-word packer; word_out holds the last completed word.
module loader_word_pack
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [23:0] sh_q;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // high in the cycle whose byte completes the word
  assign word_full = byte_en && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_out  = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (byte_en) begin
      sh_q  <= {byte_in, sh_q[23:8]};
      cnt_q <= cnt_q + 2'd1;
      if (word_full) begin
        word_q <= {byte_in, sh_q};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> 32-bit imem writes, then releases the core.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned       IMEM_DEPTH = 256,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         done,
  output logic         error,
  output logic [15:0]  words_loaded
);

  loader_state_t     state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       n_hdr;
  logic              rdy_q, we_q, done_q, crst_q, err_q;
  logic              xfer, byte_en, clr, full;
  logic [31:0]       word;

  assign xfer    = bus.in_valid && rdy_q;
  assign byte_en = (state_q == DATA) && xfer;
  assign clr     = (state_q == HDR1) && xfer;

  loader_word_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clr),
    .byte_en   (byte_en),
    .byte_in   (bus.in_data),
    .word_out  (word),
    .word_full (full)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    n_hdr   = {bus.in_data, n_q[7:0]};
    unique case (state_q)
      HDR0: begin
        if (xfer) begin
          n_d[7:0] = bus.in_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_d = n_hdr;
          if (n_hdr == '0) begin
            state_d = DONE;
          end else if (32'(n_hdr) > IMEM_DEPTH) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (full) begin
          state_d = WRITE;
          addr_d  = BASE_ADDR + ADDR_W'(32'(wl_q) * WORD_BYTES);
        end
      end
      WRITE: begin
        wl_d    = wl_q + 16'd1;
        state_d = (wl_d == n_q) ? DONE : DATA;
      end
      default: begin
      end
    endcase
  end

  // every output is a flop fed from the next state, so none can glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR0;
      n_q     <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      crst_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      rdy_q   <= accepts_bytes(state_d);
      we_q    <= (state_d == WRITE);
      done_q  <= (state_d == DONE);
      crst_q  <= (state_d == DONE);
      err_q   <= (state_d == ERR);
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign cpu_rst_n      = crst_q;
  assign done           = done_q;
  assign error          = err_q;
  assign words_loaded   = wl_q;

endmodule
